i2s_tx: RTL

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_pkg.sv | 16 +
 rtl/i2s_bclk_gen.sv | 35 +++
 rtl/i2s_tx.sv | 107 ++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S types and constants: default sample width, slot encoding on wclk, frame length.
package i2s_pkg;

  localparam int I2S_DATA_W    = 24;
  localparam int I2S_FRAME_LEN = 2 * I2S_DATA_W;

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

  function automatic int frame_len(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: i2s_bclk toggles every CLK_DIV clk, registered; no backpressure.
// bclk_rise/bclk_fall are one-clk strobes on the clk whose edge makes the toggle.
module i2s_bclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic i2s_bclk,
  output logic bclk_rise,
  output logic bclk_fall
);

  localparam int               DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick      = (div_q == DIV_MAX);
  assign bclk_rise = tick & ~i2s_bclk;
  assign bclk_fall = tick & i2s_bclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      i2s_bclk <= 1'b0;
    end else if (tick) begin
      div_q    <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter, one L/R pair per 2*DATA_W-bit frame with one-bit delay; L MSB on dout within one frame + one bclk of acceptance.
// Single holding register, s_ready low while full. Define I2S_TX_UNDERRUN_REPEAT_EN to resend the last pair on underrun instead of zeros.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W  = I2S_DATA_W,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_dataL,
  input  logic [DATA_W-1:0] s_dataR,
  output logic              i2s_bclk,
  output logic              i2s_wclk,
  output logic              dout,
  output logic              underrun
);

  localparam int               FRAME_LEN = frame_len(DATA_W);
  localparam int               CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_RIGHT = CNT_W'(DATA_W);

  typedef struct packed {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } pair_t;

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("i2s_tx: CLK_DIV must be at least 2");
  end

  logic                 bclk_fall;
  logic                 unused_bclk_rise;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]     bit_cnt_nxt;
  logic [CNT_W-1:0]     bit_idx;
  logic                 hold_full;
  pair_t                hold_pair;
  pair_t                frame;
  pair_t                starve_pair;
  pair_t                next_frame;
  logic [FRAME_LEN-1:0] tx_bits;
  slot_e                slot_q;
  logic                 accept;
  logic                 load;

  i2s_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i2s_bclk  (i2s_bclk),
    .bclk_rise (unused_bclk_rise),
    .bclk_fall (bclk_fall)
  );

  assign s_ready  = ~hold_full;
  assign accept   = s_valid & ~hold_full;
  // The edge into k=1 is the load point; bit_cnt still reads 0 on that clk.
  assign load     = bclk_fall & (bit_cnt == '0);
  assign i2s_wclk = slot_q;

  always_comb begin
    bit_cnt_nxt = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    starve_pair = frame;
`else
    starve_pair = '0;
`endif
    next_frame  = hold_full ? hold_pair : starve_pair;
    tx_bits     = load ? next_frame : frame;
    // Bit sent after an edge is frame bit (old bit_cnt), i.e. one-bit I2S delay.
    bit_idx     = CNT_LAST - bit_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      slot_q    <= SLOT_LEFT;
      dout      <= 1'b0;
      hold_full <= 1'b0;
      hold_pair <= '0;
      frame     <= '0;
      underrun  <= 1'b0;
    end else begin
      underrun <= load & ~hold_full;
      if (accept) begin
        hold_full <= 1'b1;
        hold_pair <= {s_dataL, s_dataR};
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (load) begin
        frame <= next_frame;
      end
      if (bclk_fall) begin
        bit_cnt <= bit_cnt_nxt;
        slot_q  <= (bit_cnt_nxt >= CNT_RIGHT) ? SLOT_RIGHT : SLOT_LEFT;
        dout    <= tx_bits[bit_idx];
      end
    end
  end

endmodule
